// File: rtl/tap_pkg.sv
// Shared types and helpers for the tap sequence decoder.
// State encoding is 2 bits; IDLE is the reset state.
package tap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } tap_state_e;

    localparam tap_state_e STATE_RESET = IDLE;

    // Ceiling log2, used to size the inactivity timer so it can just reach
    // WINDOW_CYCLES-1 without spare headroom.
    function automatic int clog2(input int unsigned value);
        int          width;
        int unsigned rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Produces exactly one single-cycle 'rise' per high period of async_in,
// however long that period lasts. Reusable for any slow button-style input.
module sync_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Next values of the shift chain: s1/s2 synchronize, s3 remembers the last level.
    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Chain registers, cleared asynchronously so no spurious edge follows reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/tap_sequence_decoder.sv
// Groups button presses that arrive within an inactivity window into one
// event and reports the number of taps as a one-cycle strobe.
// Optional build macro: TAP_OVERFLOW_EN adds the tap_ovf output, flagging
// sequences with more than MAX_TAPS presses.
module tap_sequence_decoder
    import tap_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 50_000_000,
    parameter int unsigned MAX_TAPS      = 7,
    parameter int unsigned CNT_W         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sign,
    output logic             tap_valid,
    output logic [CNT_W-1:0] tap_count,
    output logic             busy
`ifdef TAP_OVERFLOW_EN
    ,
    output logic             tap_ovf
`endif
);

    localparam int                 TIMER_W    = clog2(WINDOW_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_TAPS);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    logic rise;

    tap_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   tap_count_q, tap_count_d;
    logic               tap_valid_q, tap_valid_d;
    logic               busy_q, busy_d;

    sync_rise_detect u_sync_rise_detect (
        .clk      (clk),
        .rst      (rst),
        .async_in (sign),
        .rise     (rise)
    );

    // Next-state, counter, timer and output-register logic. Outputs are
    // derived from the next state so that they are registered and aligned
    // with the state they describe.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        tap_count_d = tap_count_q;
        tap_valid_d = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = COUNT;
                    cnt_d   = CNT_ONE;
                    timer_d = '0;
                end
            end
            COUNT: begin
                if (rise) begin
                    // A press on the timeout cycle still wins and restarts the window.
                    timer_d = '0;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d = REPORT;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            REPORT: begin
                // A press here opens a fresh sequence; the current report is unaffected.
                if (rise) begin
                    state_d = COUNT;
                    cnt_d   = CNT_ONE;
                    timer_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tap_valid_d = (state_d == REPORT);
        busy_d      = (state_d == COUNT);
        if (state_d == REPORT) begin
            tap_count_d = cnt_q;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= STATE_RESET;
            timer_q     <= '0;
            cnt_q       <= '0;
            tap_count_q <= '0;
            tap_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            tap_count_q <= tap_count_d;
            tap_valid_q <= tap_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign tap_valid = tap_valid_q;
    assign tap_count = tap_count_q;
    assign busy      = busy_q;

`ifdef TAP_OVERFLOW_EN
    logic ovf_sticky_q, ovf_sticky_d;
    logic tap_ovf_q, tap_ovf_d;

    // Sticky overflow: cleared when a sequence opens, set by any press past saturation.
    // The reported flag is loaded alongside tap_count and held the same way.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        tap_ovf_d    = tap_ovf_q;
        if ((state_q != COUNT) && (state_d == COUNT)) begin
            ovf_sticky_d = 1'b0;
        end else if ((state_q == COUNT) && rise && (cnt_q == CNT_MAX)) begin
            ovf_sticky_d = 1'b1;
        end
        if (state_d == REPORT) begin
            tap_ovf_d = ovf_sticky_q;
        end
    end

    // Overflow registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sticky_q <= 1'b0;
            tap_ovf_q    <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            tap_ovf_q    <= tap_ovf_d;
        end
    end

    assign tap_ovf = tap_ovf_q;
`endif

endmodule
